// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer that owns the register-file write port
module reorder_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,
   output logic             write_enable,
   output logic [4:0]       write_addr,
   output logic [31:0]      write_data,
   output logic             commit_valid,
   output logic [TAG_W-1:0] commit_tag,
   output logic [TAG_W:0]   count,
   output logic             empty
);
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_ready;
   logic [4:0]       r_rd   [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;
   logic             r_we;
   logic [4:0]       r_waddr;
   logic [31:0]      r_wdata;
   logic             r_cv;
   logic [TAG_W-1:0] r_ctag;
   logic             w_alloc;
   logic             w_retire;
   logic             w_cdb;

   assign alloc_ready  = r_count != (TAG_W+1)'(DEPTH);
   assign alloc_tag    = r_tail;
   assign w_alloc      = alloc_valid & alloc_ready;
   assign w_retire     = r_valid[r_head] & r_ready[r_head];
   assign w_cdb        = cdb_valid & r_valid[cdb_tag];
   assign write_enable = r_we;
   assign write_addr   = r_waddr;
   assign write_data   = r_wdata;
   assign commit_valid = r_cv;
   assign commit_tag   = r_ctag;
   assign count        = r_count;
   assign empty        = r_count == '0;

   // entry status, pointers, occupancy and the registered commit/write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_ready <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_cv    <= 1'b0;
         r_ctag  <= '0;
      end else if (flush) begin
         r_valid <= '0;
         r_ready <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_we    <= 1'b0;
         r_cv    <= 1'b0;
      end else begin
         if (w_retire) r_valid[r_head] <= 1'b0;
         if (w_alloc) begin
            r_valid[r_tail] <= 1'b1;
            r_ready[r_tail] <= 1'b0;
            r_tail          <= r_tail + TAG_W'(1);
         end
         if (w_cdb) r_ready[cdb_tag] <= 1'b1;
         r_cv <= w_retire;
         r_we <= w_retire && r_rd[r_head] != 5'd0;
         if (w_retire) begin
            r_ctag  <= r_head;
            r_waddr <= r_rd[r_head];
            r_wdata <= r_data[r_head];
            r_head  <= r_head + TAG_W'(1);
         end
         r_count <= r_count + {{TAG_W{1'b0}}, w_alloc} - {{TAG_W{1'b0}}, w_retire};
      end
   end

   // entry payload; only meaningful while the matching valid bit is set
   always_ff @(posedge clk) begin
      if (rst_n && !flush) begin
         if (w_alloc) r_rd[r_tail] <= alloc_rd;
         if (w_cdb) r_data[cdb_tag] <= cdb_data;
      end
   end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer. It is the writer side of the architectural register file: it drives that file's write_addr, write_enable and write_data ports.
- Dispatch allocates one entry per instruction and receives a tag. The common data bus (CDB) marks entries complete.
- The head entry retires in program order and writes its result to the register file.
- It also emits commit_tag, so the register-status logic clears a register's busy state only when the tag matches.

Parameters:
- DEPTH, 16, number of entries (power of two).
- TAG_W, 4, tag width; equals log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous discard of all entries (mispredict).
- alloc_valid  input  1  dispatch requests an entry.
- alloc_rd  input  5  destination register of the allocating instruction.
- alloc_ready  output  1  entry available (combinational).
- alloc_tag  output  TAG_W  tag the current request receives; equals the tail pointer (combinational).
- cdb_valid  input  1  result broadcast.
- cdb_tag  input  TAG_W  entry that produced the result.
- cdb_data  input  32  result value.
- write_enable  output  1  register-file write strobe (registered).
- write_addr  output  5  register-file write address (registered).
- write_data  output  32  register-file write data (registered).
- commit_valid  output  1  an entry retired this cycle (registered).
- commit_tag  output  TAG_W  tag of the retired entry (registered).
- count  output  TAG_W+1  occupied entries.
- empty  output  1  count==0.

Behaviour:
- Storage: per entry, a valid bit, a ready bit, rd[4:0] and data[31:0]. Pointers head and tail are TAG_W bits wide and wrap modulo DEPTH. count is a separate counter.
- Reset (rst_n low, asynchronous): head=tail=count=0; all valid and ready bits 0; write_enable=0, write_addr=0, write_data=0, commit_valid=0, commit_tag=0.
- alloc_ready = (count != DEPTH). It does not consider a retirement in the same cycle, so a full buffer refuses allocation even while committing.
- Allocate (alloc_valid && alloc_ready at the edge): entry[tail] gets valid=1, ready=0, rd=alloc_rd; then tail = tail+1.
- CDB (cdb_valid at the edge, entry[cdb_tag].valid==1): entry[cdb_tag] gets ready=1 and data=cdb_data.
  - A broadcast to an invalid entry is ignored.
  - A repeated broadcast to an already-ready entry overwrites data.
- Retire: evaluated on registered state at each edge.
  - If entry[head] is valid and ready: commit_valid=1, commit_tag=head, write_addr=rd, write_data=data, write_enable=(rd!=0). Then entry[head].valid=0 and head = head+1.
  - Otherwise commit_valid=0 and write_enable=0; write_addr and write_data hold.
- Retire rate: at most one entry per cycle.
- Latency: a CDB write at edge N makes the entry retire-eligible at edge N+1. If the entry is at head, write_enable is high for the cycle after edge N+1. There is no same-edge CDB-to-commit bypass.
- count: +1 on allocate, -1 on retire; both in one cycle leaves it unchanged.
- Simultaneous allocate into a just-freed slot: legal only when count<DEPTH before the edge. Head and tail never alias while valid.
- Flush (synchronous, highest priority at that edge):
  - Clears every valid and ready bit and sets head=tail=count=0.
  - Forces commit_valid=0 and write_enable=0 at that edge.
  - Same-edge allocate, CDB and retire are discarded.
- Wrap-around: pointers wrap DEPTH-1 -> 0 with no special case.
- Reset mid-operation: asserting rst_n low immediately clears all state and outputs, regardless of clk.

Test Plan:
- Reset, then allocate rd=5,6,7 (tags 0,1,2). CDB tag0 data=0x11 -> next-next cycle: write_enable=1, write_addr=5, write_data=0x11, commit_tag=0, count drops to 2.
- Out-of-order completion: CDB tag2=0x33, then tag1=0x22 -> no commit until tag1 is ready; then rd6=0x22 and rd7=0x33 retire on consecutive cycles, and empty=1 afterward.
- Fill 16 entries -> alloc_ready=0, count=16. The allocation attempt is refused (tail unchanged). After one retire, alloc_ready=1 and the next alloc_tag=0 (wrap).
- Entry with rd=0 completes -> commit_valid=1, write_enable=0, head advances.
- Flush with 4 pending and the head ready on the same edge -> no commit, count=0, alloc_tag=0. A later CDB to a stale tag produces no write.
- rst_n pulsed low between clock edges with write_enable high -> all outputs 0 immediately.
